// File: rtl/inst_loader.sv
// Instruction queue loader: packs a 5-byte-per-word program stream into 39-bit
// queue entries, verifies a trailing XOR checksum and gates the core reset.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; core runs its power-up program
// S_RECV  | accepting payload bytes into the assembly register
// S_WRITE | one-cycle queue write of the assembled instruction
// S_CHECK | accepting the checksum byte
// S_DONE  | load finished; err valid, core released only on a clean load
module inst_loader #(
    parameter int INST_W = 39,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [INST_W-1:0] mem_wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              core_reset_n_o
);

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;

    state_t              state_q;
    logic [ADDR_W:0]     len_q;
    logic [2:0]          byte_cnt_q;
    logic [ADDR_W:0]     inst_cnt_q;
    logic [7:0]          csum_q;
    logic [INST_W-1:0]   asm_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [INST_W-1:0]   mem_wr_data_q;
    logic                mem_wr_en_q;
    logic                byte_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                core_rst_n_q;

    logic                xfer;
    logic                len_ok;
    logic [INST_W-1:0]   asm_d;
    logic [7:0]          csum_d;
    logic [ADDR_W:0]     inst_cnt_d;

    assign xfer       = byte_valid_i && byte_ready_q;
    assign len_ok     = (len_i != '0) && (len_i <= (ADDR_W+1)'(DEPTH));
    // Shifting 8 bits into a 39-bit register drops bit 7 of the first byte.
    assign asm_d      = {asm_q[INST_W-9:0], byte_i};
    assign csum_d     = csum_q ^ byte_i;
    assign inst_cnt_d = inst_cnt_q + (ADDR_W+1)'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            byte_cnt_q    <= '0;
            inst_cnt_q    <= '0;
            csum_q        <= '0;
            asm_q         <= '0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_wr_en_q   <= 1'b0;
            byte_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            core_rst_n_q  <= 1'b1;
        end else begin
            mem_wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        if (len_ok) begin
                            state_q      <= S_RECV;
                            len_q        <= len_i;
                            byte_cnt_q   <= '0;
                            inst_cnt_q   <= '0;
                            csum_q       <= '0;
                            mem_addr_q   <= '0;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                            done_q       <= 1'b0;
                            err_q        <= 1'b0;
                            core_rst_n_q <= 1'b0;
                        end else begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            err_q        <= 1'b1;
                            core_rst_n_q <= 1'b0;
                        end
                    end
                end
                S_RECV: begin
                    if (xfer) begin
                        asm_q  <= asm_d;
                        csum_q <= csum_d;
                        if (byte_cnt_q == 3'd4) begin
                            byte_cnt_q    <= '0;
                            mem_wr_data_q <= asm_d;
                            mem_wr_en_q   <= 1'b1;
                            byte_ready_q  <= 1'b0;
                            state_q       <= S_WRITE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    // Address wraps to 0 after entry DEPTH-1; unused until the next load.
                    mem_addr_q   <= mem_addr_q + ADDR_W'(1);
                    inst_cnt_q   <= inst_cnt_d;
                    byte_ready_q <= 1'b1;
                    state_q      <= (inst_cnt_d == len_q) ? S_CHECK : S_RECV;
                end
                S_CHECK: begin
                    if (xfer) begin
                        err_q        <= (byte_i != csum_q);
                        core_rst_n_q <= (byte_i == csum_q);
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        byte_ready_q <= 1'b0;
                        state_q      <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready_o   = byte_ready_q;
    assign mem_wr_en_o    = mem_wr_en_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wr_data_o  = mem_wr_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign core_reset_n_o = core_rst_n_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: clean, gapped, bad-checksum, bad-len,
// full-depth and mid-load-reset programs checked against a bench-side word model.
module tb_inst_loader;

    localparam int INST_W = 39;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [ADDR_W:0]   len_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              mem_wr_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [INST_W-1:0] mem_wr_data_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              core_reset_n_o;

    inst_loader #(.INST_W(INST_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start_i),
        .len_i          (len_i),
        .byte_i         (byte_i),
        .byte_valid_i   (byte_valid_i),
        .byte_ready_o   (byte_ready_o),
        .mem_wr_en_o    (mem_wr_en_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .core_reset_n_o (core_reset_n_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ready_in_write = 0;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [INST_W-1:0] wr_data[$];
    logic [7:0]        prog[0:5*DEPTH-1];

    always @(negedge clk) begin
        if (mem_wr_en_o) begin
            wr_addr.push_back(mem_addr_o);
            wr_data.push_back(mem_wr_data_o);
            if (byte_ready_o) ready_in_write++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [INST_W-1:0] word_of(input int i);
        logic [7:0] b0;
        b0 = prog[5*i];
        return {b0[6:0], prog[5*i+1], prog[5*i+2], prog[5*i+3], prog[5*i+4]};
    endfunction

    task automatic pulse_start(input int L);
        start_i = 1'b1;
        len_i   = (ADDR_W+1)'(L);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        int n;
        repeat (gap) begin
            byte_valid_i = 1'b0;
            @(posedge clk); #1;
        end
        byte_valid_i = 1'b1;
        byte_i       = b;
        n = 0;
        do begin
            rdy = byte_ready_o;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("byte_ready timeout", byte_ready_o, 1);
        byte_valid_i = 1'b0;
    endtask

    task automatic run_load(input int L, input int gap, input bit bad, input bit poke, input string tag);
        logic [7:0] cs;
        wr_addr.delete();
        wr_data.delete();
        ready_in_write = 0;
        pulse_start(L);
        chk({tag, " busy after start"}, busy_o, 1);
        chk({tag, " core held"}, core_reset_n_o, 0);
        if (poke) pulse_start(0);
        cs = 8'h00;
        for (int i = 0; i < 5*L; i++) begin
            send_byte(prog[i], gap);
            cs ^= prog[i];
        end
        send_byte(bad ? (cs ^ 8'h01) : cs, gap);
        chk({tag, " done"}, done_o, 1);
        chk({tag, " err"}, err_o, bad);
        chk({tag, " core_reset_n"}, core_reset_n_o, !bad);
        chk({tag, " busy cleared"}, busy_o, 0);
        chk({tag, " write count"}, wr_addr.size(), L);
        chk({tag, " ready low in write"}, ready_in_write, 0);
        for (int i = 0; i < L && i < wr_addr.size(); i++) begin
            chk({tag, $sformatf(" addr[%0d]", i)}, wr_addr[i], i % DEPTH);
            chk({tag, $sformatf(" data[%0d]", i)}, wr_data[i], word_of(i));
        end
        chk({tag, " final mem_addr"}, mem_addr_o, L % DEPTH);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_i = 1'b0; len_i = '0; byte_i = '0; byte_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset byte_ready", byte_ready_o, 0);
        chk("reset busy", busy_o, 0);
        chk("reset done", done_o, 0);
        chk("reset err", err_o, 0);
        chk("reset core_reset_n", core_reset_n_o, 1);
        chk("reset mem_wr_en", mem_wr_en_o, 0);
        chk("reset mem_addr", mem_addr_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single instruction, clean
        prog[0] = 8'h03; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00; prog[4] = 8'h05;
        chk("t1 model word", word_of(0), 39'h03_0000_0005);
        run_load(1, 0, 1'b0, 1'b0, "t1");

        // 2: two instructions with 3-cycle valid gaps, start poked while busy
        prog[0] = 8'h81; prog[1] = 8'h12; prog[2] = 8'h34; prog[3] = 8'h56; prog[4] = 8'h78;
        prog[5] = 8'h7F; prog[6] = 8'hAA; prog[7] = 8'hBB; prog[8] = 8'hCC; prog[9] = 8'hDD;
        run_load(2, 3, 1'b0, 1'b1, "t2");
        chk("t2 word0 literal", wr_data.size() > 0 ? wr_data[0] : '0, 39'h01_1234_5678);

        // 3: bad checksum, then clean restart from DONE
        prog[0] = 8'h03; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00; prog[4] = 8'h05;
        run_load(1, 0, 1'b1, 1'b0, "t3 bad");
        repeat (3) @(posedge clk); #1;
        chk("t3 core stays held", core_reset_n_o, 0);
        chk("t3 err held", err_o, 1);
        run_load(1, 1, 1'b0, 1'b0, "t3 retry");

        // 4: illegal lengths
        wr_addr.delete();
        pulse_start(65);
        chk("t4 len65 done", done_o, 1);
        chk("t4 len65 err", err_o, 1);
        chk("t4 len65 busy", busy_o, 0);
        chk("t4 len65 core held", core_reset_n_o, 0);
        run_load(1, 0, 1'b0, 1'b0, "t4 clean");
        wr_addr.delete();
        pulse_start(0);
        chk("t4 len0 done", done_o, 1);
        chk("t4 len0 err", err_o, 1);
        chk("t4 len0 ready", byte_ready_o, 0);
        repeat (5) @(posedge clk); #1;
        chk("t4 no writes", wr_addr.size(), 0);

        // 5: full depth with random payload
        for (int i = 0; i < 5*DEPTH; i++) prog[i] = 8'($urandom_range(0, 255));
        run_load(DEPTH, 0, 1'b0, 1'b0, "t5");

        // 6: reset after 3rd byte of the second instruction
        wr_addr.delete();
        pulse_start(2);
        for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
        chk("t6 first entry written", wr_addr.size(), 1);
        rst_n = 1'b0;
        #1;
        chk("t6 rst busy", busy_o, 0);
        chk("t6 rst byte_ready", byte_ready_o, 0);
        chk("t6 rst core_reset_n", core_reset_n_o, 1);
        chk("t6 rst mem_addr", mem_addr_o, 0);
        chk("t6 rst mem_wr_data", mem_wr_data_o, 0);
        chk("t6 rst done", done_o, 0);
        chk("t6 rst err", err_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        prog[0] = 8'h55; prog[1] = 8'h01; prog[2] = 8'h23; prog[3] = 8'h45; prog[4] = 8'h67;
        run_load(1, 0, 1'b0, 1'b0, "t6 reload");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Upstream stage of the instruction queue. Receives a program as an 8-bit byte stream over a valid/ready handshake.
- Packs every 5 bytes into one 39-bit instruction and writes it into the queue memory, starting at address 0.
- Checks a trailing XOR checksum byte at the end of the program.
- Holds the core's instruction counter in reset (core_reset_n) while loading, and releases it only after a clean load.

Parameters:
- INST_W, 39, instruction width; fixed by the decoder format (opcode in [38:36]).
- ADDR_W, 6, queue address width.
- DEPTH, 64, number of queue entries; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- len  input  ADDR_W+1  number of instructions to load, sampled on the accepted start; legal range 1..DEPTH.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte; a byte transfers when byte_valid && byte_ready at a rising edge.
- mem_wr_en  output  1  queue write strobe, exactly one cycle per instruction.
- mem_addr  output  ADDR_W  queue write address.
- mem_wr_data  output  INST_W  assembled instruction.
- busy  output  1  high in RECV, WRITE and CHECK.
- done  output  1  high while in DONE.
- err  output  1  valid while done is high: bad len or checksum mismatch.
- core_reset_n  output  1  drives the counter reset; low holds the core at instruction 0.

Behaviour:
- Reset values (asynchronous on reset low):
  - state = IDLE.
  - byte_ready, mem_wr_en, busy, done, err = 0.
  - core_reset_n = 1; the power-up program from memory initialisation runs.
  - mem_addr = 0, mem_wr_data = 0; internal byte count, instruction count and checksum cleared.
- IDLE:
  - start=1 with len in 1..DEPTH: latch len, clear address/counters/checksum, go to RECV.
  - start=1 with len = 0 or len > DEPTH: go to DONE with err=1; no memory writes.
- RECV (byte_ready=1):
  - On each transfer, shift the byte into the assembly register, MSB-first. Byte 0 bits [6:0] become inst[38:32]; bytes 1..4 become [31:24], [23:16], [15:8], [7:0].
  - Byte 0 bit 7 is discarded but still included in the checksum.
  - Checksum = running XOR of every accepted payload byte.
  - After the 5th byte transfers, go to WRITE.
- WRITE (byte_ready=0):
  - mem_wr_en=1 for exactly one cycle, with mem_addr = instruction index and mem_wr_data = the assembled word.
  - On the next edge, increment mem_addr.
  - If the instruction count now equals len, go to CHECK; otherwise return to RECV.
  - Each 5-byte instruction therefore costs at least 6 cycles.
- CHECK (byte_ready=1):
  - Accept one byte. err = (byte != checksum). Go to DONE.
- DONE:
  - done=1, err held.
  - core_reset_n = ~err: a clean load restarts the core from address 0; a failed load keeps the core held in reset.
  - A new start pulse behaves as in IDLE (restart allowed).
- core_reset_n is 0 from the cycle after an accepted start through RECV, WRITE and CHECK.
- start while busy is ignored.
- byte_valid while byte_ready=0: no transfer, the byte is not consumed. The source must hold byte_in stable until ready.
- Wrap-around: len = DEPTH writes addresses 0..DEPTH-1. mem_addr wraps to 0 after the last write and is not reused before CHECK.
- Reset mid-load: immediate return to IDLE with core_reset_n=1. The partial word is discarded; entries already written stay in the queue memory.
- All outputs are registered; there are no combinational paths from byte_valid to byte_ready.

Test Plan:
1. len=1; bytes 0x03,0x00,0x00,0x00,0x05, checksum 0x06 -> one write, mem_addr=0, mem_wr_data=39'h03_0000_0005; done=1, err=0, core_reset_n=1.
2. len=2 with valid gaps (byte_valid low 3 cycles between bytes) -> exactly two mem_wr_en pulses, at addr 0 then addr 1; no byte duplicated or lost; byte_ready=0 during each WRITE cycle.
3. Same as 1 but checksum byte 0x07 -> err=1, done=1, core_reset_n stays 0; a following start with len=1 and correct data -> err=0, core_reset_n=1.
4. start with len=0, and separately len=65 -> DONE with err=1 within 1 cycle; mem_wr_en never asserted.
5. len=64 with random data -> 64 writes at addresses 0..63, each matching the expected word; mem_addr wraps to 0; checksum passes.
6. reset pulled low after the 3rd byte of instruction 2 -> all outputs at reset values the same cycle; a later clean len=1 load writes addr 0 correctly.
